// File: rtl/dm_cache_pkg.sv
// Shared definitions for the direct-mapped cache: controller state encoding
// and the address-field width helpers used to size tag/index/offset slices.
package dm_cache_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    WRITE  = 2'd2,
    RESP   = 2'd3
  } state_t;

  function automatic int idx_w(input int num_blocks);
    return $clog2(num_blocks);
  endfunction

  function automatic int off_w(input int words);
    return $clog2(words);
  endfunction

  // Word-addressed tag: 30 word-address bits minus index and offset.
  function automatic int tag_w(input int num_blocks, input int words);
    return 30 - $clog2(num_blocks) - $clog2(words);
  endfunction

endpackage

// File: rtl/dm_cache_if.sv
// CPU-side and memory-side bus of the cache; slave is the cache's view,
// master is the view of whatever drives the CPU requests and the memory.
interface dm_cache_if #(
  parameter int WORDS = 4
);
  logic                  cpu_req;
  logic                  cpu_we;
  logic [31:0]           cpu_addr;
  logic [31:0]           cpu_wdata;
  logic [31:0]           cpu_rdata;
  logic                  cpu_ready;
  logic                  cpu_hit;
  logic                  mem_rd_req;
  logic [31:0]           mem_addr;
  logic [32*WORDS-1:0]   mem_rdata;
  logic                  mem_rd_valid;
  logic                  mem_wr_req;
  logic [31:0]           mem_wdata;
  logic                  mem_wr_ack;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata, mem_rd_valid, mem_wr_ack,
    output cpu_rdata, cpu_ready, cpu_hit, mem_rd_req, mem_addr, mem_wr_req, mem_wdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata, mem_rd_valid, mem_wr_ack,
    input  cpu_rdata, cpu_ready, cpu_hit, mem_rd_req, mem_addr, mem_wr_req, mem_wdata
  );
endinterface

// File: rtl/dm_cache_array.sv
// Line storage: valid bits (resettable, flushable), tag and data arrays with
// one synchronous write port and a combinational read port.
module dm_cache_array
  import dm_cache_pkg::*;
#(
  parameter  int NUM_BLOCKS = 8,
  parameter  int WORDS      = 4,
  localparam int BLOCK_W    = 32 * WORDS,
  localparam int IDX_W      = idx_w(NUM_BLOCKS),
  localparam int TAG_W      = tag_w(NUM_BLOCKS, WORDS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               we,
  input  logic [IDX_W-1:0]   widx,
  input  logic [TAG_W-1:0]   wtag,
  input  logic [BLOCK_W-1:0] wdata,
  input  logic [IDX_W-1:0]   ridx,
  output logic               rvalid,
  output logic [TAG_W-1:0]   rtag,
  output logic [BLOCK_W-1:0] rdata
);

  logic [NUM_BLOCKS-1:0] valid_q;
  logic [TAG_W-1:0]      tag_mem  [NUM_BLOCKS];
  logic [BLOCK_W-1:0]    data_mem [NUM_BLOCKS];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (flush) begin
      valid_q <= '0;
    end else if (we) begin
      valid_q[widx] <= 1'b1;
    end
  end

  // NOTE: tag/data arrays carry no reset; the valid bits alone qualify their contents.
  always_ff @(posedge clk) begin
    if (we && !flush) begin
      tag_mem[widx]  <= wtag;
      data_mem[widx] <= wdata;
    end
  end

  assign rvalid = valid_q[ridx];
  assign rtag   = tag_mem[ridx];
  assign rdata  = data_mem[ridx];

endmodule

// File: rtl/dm_cache.sv
// Direct-mapped, write-through, no-write-allocate cache controller with
// saturating hit/miss statistics.
module dm_cache
  import dm_cache_pkg::*;
#(
  parameter int NUM_BLOCKS = 8,
  parameter int WORDS      = 4,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  dm_cache_if.slave         bus,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);

  localparam int BLOCK_W = 32 * WORDS;
  localparam int IDX_W   = idx_w(NUM_BLOCKS);
  localparam int OFF_W   = off_w(WORDS);
  localparam int TAG_W   = tag_w(NUM_BLOCKS, WORDS);

  state_t       state;
  logic [29:0]  req_waddr;   // latched word address of the access in flight
  logic         lookup_hit;

  logic [OFF_W-1:0]   cpu_off;
  logic [IDX_W-1:0]   cpu_idx, req_idx;
  logic [TAG_W-1:0]   cpu_tag, req_tag;
  logic               arr_rvalid, arr_we, arr_flush, hit, accept;
  logic [TAG_W-1:0]   arr_rtag, arr_wtag;
  logic [IDX_W-1:0]   arr_widx;
  logic [BLOCK_W-1:0] arr_rdata, arr_wdata;
  logic               unused_addr_bits;

  assign cpu_off = bus.cpu_addr[OFF_W+1:2];
  assign cpu_idx = bus.cpu_addr[OFF_W+IDX_W+1:OFF_W+2];
  assign cpu_tag = bus.cpu_addr[31:OFF_W+IDX_W+2];
  assign req_idx = req_waddr[OFF_W+IDX_W-1:OFF_W];
  assign req_tag = req_waddr[29:OFF_W+IDX_W];
  assign unused_addr_bits = ^bus.cpu_addr[1:0];

  assign hit       = arr_rvalid && (arr_rtag == cpu_tag);
  assign arr_flush = (state == IDLE) && flush;
  assign accept    = (state == IDLE) && bus.cpu_req && !flush;

  function automatic logic [31:0] pick(input logic [BLOCK_W-1:0] line, input logic [OFF_W-1:0] off);
    return line[{off, 5'b0} +: 32];
  endfunction

  // Write hits merge one word into the looked-up line; refills install a whole line.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    arr_we    = 1'b0;
    arr_widx  = cpu_idx;
    arr_wtag  = cpu_tag;
    arr_wdata = arr_rdata;
    if (accept && bus.cpu_we && hit) begin
      arr_we = 1'b1;
      arr_wdata[{cpu_off, 5'b0} +: 32] = bus.cpu_wdata;
    end else if (state == REFILL && bus.mem_rd_valid) begin
      arr_we    = 1'b1;
      arr_widx  = req_idx;
      arr_wtag  = req_tag;
      arr_wdata = bus.mem_rdata;
    end
  end

  dm_cache_array #(
    .NUM_BLOCKS(NUM_BLOCKS),
    .WORDS     (WORDS)
  ) u_array (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (arr_flush),
    .we    (arr_we),
    .widx  (arr_widx),
    .wtag  (arr_wtag),
    .wdata (arr_wdata),
    .ridx  (cpu_idx),
    .rvalid(arr_rvalid),
    .rtag  (arr_rtag),
    .rdata (arr_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      req_waddr      <= '0;
      lookup_hit     <= 1'b0;
      bus.cpu_ready  <= 1'b0;
      bus.cpu_hit    <= 1'b0;
      bus.cpu_rdata  <= '0;
      bus.mem_rd_req <= 1'b0;
      bus.mem_wr_req <= 1'b0;
      bus.mem_addr   <= '0;
      bus.mem_wdata  <= '0;
      hit_cnt        <= '0;
      miss_cnt       <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          req_waddr <= bus.cpu_addr[31:2];
          if (bus.cpu_we) begin
            state          <= WRITE;
            lookup_hit     <= hit;
            bus.mem_wr_req <= 1'b1;
            bus.mem_addr   <= {bus.cpu_addr[31:2], 2'b00};
            bus.mem_wdata  <= bus.cpu_wdata;
          end else if (hit) begin
            state         <= RESP;
            bus.cpu_ready <= 1'b1;
            bus.cpu_hit   <= 1'b1;
            bus.cpu_rdata <= pick(arr_rdata, cpu_off);
          end else begin
            state          <= REFILL;
            bus.mem_rd_req <= 1'b1;
            bus.mem_addr   <= {bus.cpu_addr[31:OFF_W+2], {(OFF_W+2){1'b0}}};
          end
        end
        REFILL: if (bus.mem_rd_valid) begin
          state          <= RESP;
          bus.mem_rd_req <= 1'b0;
          bus.cpu_ready  <= 1'b1;
          bus.cpu_hit    <= 1'b0;
          bus.cpu_rdata  <= pick(bus.mem_rdata, req_waddr[OFF_W-1:0]);
        end
        WRITE: if (bus.mem_wr_ack) begin
          state          <= RESP;
          bus.mem_wr_req <= 1'b0;
          bus.cpu_ready  <= 1'b1;
          bus.cpu_hit    <= lookup_hit;
        end
        RESP: begin
          state         <= IDLE;
          bus.cpu_ready <= 1'b0;
          bus.cpu_hit   <= 1'b0;
          if (bus.cpu_hit) begin
            if (hit_cnt != '1) hit_cnt <= hit_cnt + CNT_W'(1);
          end else begin
            if (miss_cnt != '1) miss_cnt <= miss_cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_cache.sv
// Directed scoreboard bench for dm_cache: the driver queues the expected
// response of each access, a monitor compares it when cpu_ready pulses.
module tb_dm_cache;

  localparam int CNT_MAX = 3;   // CNT_W = 2

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic [1:0] hit_cnt, miss_cnt;

  dm_cache_if #(.WORDS(4)) bus ();

  dm_cache #(.NUM_BLOCKS(8), .WORDS(4), .CNT_W(2)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .bus     (bus),
    .hit_cnt (hit_cnt),
    .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_read;
    logic [31:0] rdata;
    logic        hit;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          exp_hits = 0;
  int          exp_miss = 0;
  int          rd_delay = 2;
  int          wr_delay = 1;
  int          rd_reqs = 0;
  int          wr_held = 0;
  logic        both_seen = 1'b0;
  logic        busy_flush = 1'b0;
  logic [31:0] exp_mem_addr = '0;
  logic [31:0] exp_wdata = '0;
  logic [31:0] mem_model [logic [31:0]];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] line_of(input logic [31:0] addr);
    logic [127:0] line;
    logic [31:0]  a;
    for (int w = 0; w < 4; w++) begin
      a = {addr[31:4], 4'b0} + 32'(4 * w);
      line[32*w +: 32] = mem_model.exists(a) ? mem_model[a] : 32'h0;
    end
    return line;
  endfunction

  // Memory responder: acknowledges after a programmable number of held cycles.
  initial begin
    int rd_k = 0;
    int wr_k = 0;
    bus.mem_rd_valid = 1'b0;
    bus.mem_wr_ack   = 1'b0;
    bus.mem_rdata    = '0;
    forever begin
      @(negedge clk);
      bus.mem_rd_valid = 1'b0;
      bus.mem_wr_ack   = 1'b0;
      if (bus.mem_rd_req && bus.mem_wr_req) both_seen = 1'b1;
      if (bus.mem_rd_req) begin
        rd_k++;
        if (rd_k == 1) rd_reqs++;
        check("refill_addr", bus.mem_addr, exp_mem_addr);
        if (rd_k == rd_delay) begin
          bus.mem_rd_valid = 1'b1;
          bus.mem_rdata    = line_of(bus.mem_addr);
          rd_k = 0;
        end
      end else begin
        rd_k = 0;
      end
      if (bus.mem_wr_req) begin
        wr_k++;
        check("write_addr", bus.mem_addr, exp_mem_addr);
        check("write_data", bus.mem_wdata, exp_wdata);
        if (wr_k == wr_delay) begin
          bus.mem_wr_ack = 1'b1;
          mem_model[bus.mem_addr] = bus.mem_wdata;
          wr_held = wr_k;
          wr_k = 0;
        end
      end else begin
        wr_k = 0;
      end
    end
  end

  // Monitor: pops one expectation per cpu_ready pulse.
  initial begin
    logic prev_ready = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.cpu_ready === 1'b1) begin
        check("ready_single_cycle", prev_ready, 1'b0);
        if (sb.size() == 0) begin
          check("unexpected_ready", 1'b1, 1'b0);
        end else begin
          e = sb.pop_front();
          check({e.name, "_hit"}, bus.cpu_hit, e.hit);
          if (e.is_read) check({e.name, "_rdata"}, bus.cpu_rdata, e.rdata);
        end
      end
      prev_ready = bus.cpu_ready;
    end
  end

  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_hit, input string name);
    exp_t e;
    int   lat;
    int   rd_before;
    e.is_read = !we;
    e.rdata   = exp_rdata;
    e.hit     = exp_hit;
    e.name    = name;
    sb.push_back(e);
    rd_before = rd_reqs;
    @(negedge clk);
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = we;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wdata;
    exp_mem_addr  = we ? {addr[31:2], 2'b00} : {addr[31:4], 4'b0000};
    exp_wdata     = wdata;
    @(posedge clk);
    #1;
    bus.cpu_req = 1'b0;
    if (busy_flush) flush = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (bus.cpu_ready !== 1'b1 && lat < 200);
    flush = 1'b0;
    if (lat >= 200) check({name, "_timeout"}, 1'b1, 1'b0);
    if (!we && exp_hit) begin
      check({name, "_latency"}, lat, 1);
      check({name, "_no_refill"}, rd_reqs, rd_before);
    end else if (!we) begin
      check({name, "_one_refill"}, rd_reqs, rd_before + 1);
    end else begin
      check({name, "_wr_held"}, wr_held, wr_delay);
      check({name, "_no_refill"}, rd_reqs, rd_before);
    end
    if (exp_hit) exp_hits = (exp_hits < CNT_MAX) ? exp_hits + 1 : CNT_MAX;
    else         exp_miss = (exp_miss < CNT_MAX) ? exp_miss + 1 : CNT_MAX;
    @(posedge clk);
    #1;
    check({name, "_hit_cnt"}, hit_cnt, exp_hits);
    check({name, "_miss_cnt"}, miss_cnt, exp_miss);
  endtask

  function automatic logic [103:0] out_vec();
    return {bus.cpu_ready, bus.cpu_hit, bus.mem_rd_req, bus.mem_wr_req,
            bus.cpu_rdata, bus.mem_addr, bus.mem_wdata, hit_cnt, miss_cnt};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    for (int w = 0; w < 4; w++) begin
      mem_model[32'h40  + 32'(4*w)] = 32'h11 * 32'(w + 1);
      mem_model[32'hC0  + 32'(4*w)] = 32'hA0 + 32'(w);
      mem_model[32'h100 + 32'(4*w)] = 32'hB0 + 32'(w);
    end

    repeat (3) @(negedge clk);
    check("reset_outputs", out_vec(), '0);
    rst_n = 1'b1;

    // Cold miss, then hit within the same line.
    access(1'b0, 32'h40, '0, 32'h11, 1'b0, "rd40_miss");
    access(1'b0, 32'h48, '0, 32'h33, 1'b1, "rd48_hit");

    // Write hit with a slow acknowledge, then read back the merged word.
    wr_delay = 3;
    access(1'b1, 32'h44, 32'hDEADBEEF, '0, 1'b1, "wr44_hit");
    wr_delay = 1;
    access(1'b0, 32'h44, '0, 32'hDEADBEEF, 1'b1, "rd44_hit");

    // Conflict eviction on index 4.
    access(1'b0, 32'hC0, '0, 32'hA0, 1'b0, "rdC0_miss");
    access(1'b0, 32'h40, '0, 32'h11, 1'b0, "rd40_evicted");

    // flush while busy is ignored: the refilled line must survive.
    busy_flush = 1'b1;
    access(1'b0, 32'hCC, '0, 32'hA3, 1'b0, "rdCC_miss_flush_busy");
    busy_flush = 1'b0;
    access(1'b0, 32'hC8, '0, 32'hA2, 1'b1, "rdC8_hit");

    // flush beats a simultaneous request in IDLE.
    @(negedge clk);
    flush        = 1'b1;
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 32'hC0;
    @(posedge clk);
    #1;
    check("flush_blocks_req", {bus.cpu_ready, bus.mem_rd_req}, 2'b00);
    flush       = 1'b0;
    bus.cpu_req = 1'b0;
    access(1'b0, 32'hC4, '0, 32'hA1, 1'b0, "rdC4_after_flush");

    // Write miss leaves the resident line of that index untouched.
    access(1'b0, 32'h104, '0, 32'hB1, 1'b0, "rd104_miss");
    access(1'b1, 32'h208, 32'h55, '0, 1'b0, "wr208_miss");
    access(1'b0, 32'h108, '0, 32'hB2, 1'b1, "rd108_hit");
    access(1'b0, 32'h208, '0, 32'h55, 1'b0, "rd208_no_alloc");

    // Reset in the middle of a refill aborts it.
    rd_delay = 100;
    @(negedge clk);
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 32'h100;
    exp_mem_addr = 32'h100;
    @(posedge clk);
    #1;
    bus.cpu_req = 1'b0;
    repeat (2) @(negedge clk);
    check("refill_pending", bus.mem_rd_req, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_mid_refill_outputs", out_vec(), '0);
    @(negedge clk);
    rst_n    = 1'b1;
    rd_delay = 2;
    exp_hits = 0;
    exp_miss = 0;
    access(1'b0, 32'h100, '0, 32'hB0, 1'b0, "rd100_after_reset");

    // Hit counter saturates at 3.
    for (int i = 0; i < 4; i++) access(1'b0, 32'h10C, '0, 32'hB3, 1'b1, "rd10C_sat");

    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    check("rd_wr_req_exclusive", both_seen, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
